// File: rtl/serial_code_decoder.sv
// Bit-serial receiver: assembles 4-bit code symbols and decodes them
// (Gray->binary, Excess-3->BCD, passthrough), flagging invalid symbols.
module serial_code_decoder #(
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned ERR_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin_valid,
  input  logic             sin_bit,
  input  logic             sin_start,
  input  logic [1:0]       mode,
  output logic [3:0]       dout,
  output logic             dout_valid,
  output logic             dout_err,
  output logic             busy,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned      SYM_W   = 4;
  localparam int unsigned      CNT_W   = 2;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SYM_W-1:0]   r_shift;
  logic [SYM_W-1:0]   w_shift_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [1:0]         r_mode;
  logic [1:0]         w_mode_nxt;
  logic [SYM_W-1:0]   w_dout_nxt;
  logic               w_dout_valid_nxt;
  logic               w_dout_err_nxt;
  logic               w_busy_nxt;
  logic [ERR_W-1:0]   w_err_count_nxt;
  logic               w_err_inc;
  logic [SYM_W-1:0]   w_shift_in;
  logic [SYM_W-1:0]   w_dec;
  logic               w_dec_err;

  // Shift register with the current bit merged in; on the 4th bit this is the full symbol
  always_comb begin
    w_shift_in = r_shift;
    if (MSB_FIRST) begin
      w_shift_in = {r_shift[SYM_W-2:0], sin_bit};
    end else begin
      w_shift_in[r_cnt] = sin_bit;
    end
  end

  // Symbol decode under the mode latched at the first bit
  always_comb begin
    w_dec     = '0;
    w_dec_err = 1'b0;
    case (r_mode)
      2'b00: begin
        w_dec[3] = w_shift_in[3];
        w_dec[2] = w_dec[3] ^ w_shift_in[2];
        w_dec[1] = w_dec[2] ^ w_shift_in[1];
        w_dec[0] = w_dec[1] ^ w_shift_in[0];
      end
      2'b01: begin
        if ((w_shift_in >= 4'd3) && (w_shift_in <= 4'd12)) begin
          w_dec = w_shift_in - 4'd3;
        end else begin
          w_dec_err = 1'b1;
        end
      end
      2'b10:   w_dec = w_shift_in;
      default: w_dec_err = 1'b1;
    endcase
  end

  // Next-state and output logic
  always_comb begin
    w_state_nxt      = r_state;
    w_shift_nxt      = r_shift;
    w_cnt_nxt        = r_cnt;
    w_mode_nxt       = r_mode;
    w_dout_nxt       = dout;
    w_dout_valid_nxt = 1'b0;
    w_dout_err_nxt   = dout_err;
    w_busy_nxt       = busy;
    w_err_count_nxt  = err_count;
    w_err_inc        = 1'b0;

    case (r_state)
      IDLE: begin
        if (sin_valid && sin_start) begin
          w_shift_nxt = {{(SYM_W-1){1'b0}}, sin_bit};
          w_cnt_nxt   = CNT_W'(1);
          w_mode_nxt  = mode;
          w_state_nxt = SHIFT;
          w_busy_nxt  = 1'b1;
        end
      end
      SHIFT: begin
        if (sin_valid) begin
          if (sin_start) begin
            // Framing abort: drop the partial symbol and restart on this bit
            w_err_inc   = 1'b1;
            w_shift_nxt = {{(SYM_W-1){1'b0}}, sin_bit};
            w_cnt_nxt   = CNT_W'(1);
            w_mode_nxt  = mode;
          end else if (r_cnt == CNT_W'(3)) begin
            w_dout_nxt       = w_dec;
            w_dout_err_nxt   = w_dec_err;
            w_dout_valid_nxt = 1'b1;
            w_err_inc        = w_dec_err;
            w_shift_nxt      = '0;
            w_cnt_nxt        = '0;
            w_state_nxt      = IDLE;
            w_busy_nxt       = 1'b0;
          end else begin
            w_shift_nxt = w_shift_in;
            w_cnt_nxt   = r_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase

    if (w_err_inc && (err_count != ERR_MAX)) begin
      w_err_count_nxt = err_count + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_mode     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_err   <= 1'b0;
      busy       <= 1'b0;
      err_count  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_cnt      <= w_cnt_nxt;
      r_mode     <= w_mode_nxt;
      dout       <= w_dout_nxt;
      dout_valid <= w_dout_valid_nxt;
      dout_err   <= w_dout_err_nxt;
      busy       <= w_busy_nxt;
      err_count  <= w_err_count_nxt;
    end
  end

endmodule

// File: tb/tb_serial_code_decoder.sv
// Scoreboard bench for serial_code_decoder: instance 0 is MSB-first/ERR_W=8,
// instance 1 is LSB-first/ERR_W=2; a monitor per instance checks each output pulse.
module tb_serial_code_decoder;

  typedef struct packed {
    logic [3:0] dout;
    logic       err;
    logic [7:0] ec;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       sv [2];
  logic       sb [2];
  logic       ss [2];
  logic [1:0] sm [2];
  logic [3:0] dout [2];
  logic       dv [2];
  logic       de [2];
  logic       bsy [2];
  logic [7:0] ec0;
  logic [1:0] ec1;

  exp_t q0[$];
  exp_t q1[$];
  int   n_cmp;
  int   n_err;

  serial_code_decoder #(.MSB_FIRST(1'b1), .ERR_W(8)) u_dut0 (
    .clk(clk), .rst(rst), .sin_valid(sv[0]), .sin_bit(sb[0]), .sin_start(ss[0]),
    .mode(sm[0]), .dout(dout[0]), .dout_valid(dv[0]), .dout_err(de[0]),
    .busy(bsy[0]), .err_count(ec0)
  );

  serial_code_decoder #(.MSB_FIRST(1'b0), .ERR_W(2)) u_dut1 (
    .clk(clk), .rst(rst), .sin_valid(sv[1]), .sin_bit(sb[1]), .sin_start(ss[1]),
    .mode(sm[1]), .dout(dout[1]), .dout_valid(dv[1]), .dout_err(de[1]),
    .busy(bsy[1]), .err_count(ec1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ec_of(input int d);
    return (d == 0) ? 32'(ec0) : 32'(ec1);
  endfunction

  // One input cycle: present values, let the edge sample them, then deassert
  task automatic drive(input int d, input logic v, input logic b, input logic s,
                       input logic [1:0] m);
    sv[d] = v; sb[d] = b; ss[d] = s; sm[d] = m;
    @(posedge clk); #1;
    sv[d] = 1'b0; ss[d] = 1'b0; sb[d] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // bits[3] is sent first; m0 with the first bit, mr on the rest
  task automatic send_sym(input int d, input logic [3:0] bits, input logic [1:0] m0,
                          input logic [1:0] mr, input int gap, input logic [3:0] xd,
                          input logic xe, input logic [7:0] xc);
    exp_t e;
    e.dout = xd; e.err = xe; e.ec = xc;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) idle(gap);
      drive(d, 1'b1, bits[3-i], (i == 0), (i == 0) ? m0 : mr);
      if (i == 0) chk("busy_mid", 32'(bsy[d]), 32'd1);
    end
    chk("busy_done", 32'(bsy[d]), 32'd0);
  endtask

  task automatic send_partial(input int d, input logic [3:0] bits, input int n,
                              input logic [1:0] m);
    for (int i = 0; i < n; i++) drive(d, 1'b1, bits[3-i], (i == 0), m);
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    if (!rst && dv[0]) begin
      if (q0.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL d0_unexpected_valid: got dout=%0h with no expected symbol", dout[0]);
      end else begin
        exp_t e;
        e = q0.pop_front();
        chk("d0_dout", 32'(dout[0]), 32'(e.dout));
        chk("d0_err", 32'(de[0]), 32'(e.err));
        chk("d0_err_count", 32'(ec0), 32'(e.ec));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && dv[1]) begin
      if (q1.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL d1_unexpected_valid: got dout=%0h with no expected symbol", dout[1]);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("d1_dout", 32'(dout[1]), 32'(e.dout));
        chk("d1_err", 32'(de[1]), 32'(e.err));
        chk("d1_err_count", 32'(ec1), 32'(e.ec));
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      sv[d] = 1'b0; sb[d] = 1'b0; ss[d] = 1'b0; sm[d] = 2'b00;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_dout", 32'(dout[d]), 32'd0);
      chk("rst_valid", 32'(dv[d]), 32'd0);
      chk("rst_err", 32'(de[d]), 32'd0);
      chk("rst_busy", 32'(bsy[d]), 32'd0);
      chk("rst_err_count", ec_of(d), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Instance 0: MSB first
    send_sym(0, 4'b0110, 2'b00, 2'b00, 0, 4'b0100, 1'b0, 8'd0);
    idle(2);
    send_sym(0, 4'b1000, 2'b01, 2'b01, 2, 4'b0101, 1'b0, 8'd0);
    send_sym(0, 4'b0001, 2'b01, 2'b01, 0, 4'b0000, 1'b1, 8'd1);
    send_sym(0, 4'b1101, 2'b01, 2'b01, 0, 4'b0000, 1'b1, 8'd2);
    send_sym(0, 4'b1111, 2'b00, 2'b01, 0, 4'b1010, 1'b0, 8'd2);
    send_sym(0, 4'b0011, 2'b01, 2'b01, 0, 4'b0000, 1'b0, 8'd2);
    send_sym(0, 4'b1100, 2'b01, 2'b01, 1, 4'b1001, 1'b0, 8'd2);
    chk("d0_dout_hold", 32'(dout[0]), 32'h9);
    idle(1);
    // Framing abort after two bits, then a clean symbol
    send_partial(0, 4'b1000, 2, 2'b01);
    chk("abort_busy", 32'(bsy[0]), 32'd1);
    send_sym(0, 4'b0111, 2'b10, 2'b10, 0, 4'b0111, 1'b0, 8'd3);
    chk("abort_err_count", ec0, 32'd3);
    // Back-to-back symbols, second in reserved mode
    send_sym(0, 4'b1010, 2'b10, 2'b10, 0, 4'b1010, 1'b0, 8'd3);
    send_sym(0, 4'b0000, 2'b11, 2'b11, 0, 4'b0000, 1'b1, 8'd4);
    // Bits without a start marker are ignored in IDLE
    drive(0, 1'b1, 1'b1, 1'b0, 2'b10);
    drive(0, 1'b1, 1'b0, 1'b0, 2'b10);
    chk("idle_ignore_busy", 32'(bsy[0]), 32'd0);
    send_sym(0, 4'b0011, 2'b10, 2'b10, 0, 4'b0011, 1'b0, 8'd4);
    idle(2);
    // Asynchronous reset mid-symbol
    send_partial(0, 4'b1110, 3, 2'b10);
    #2 rst = 1'b1;
    #1;
    chk("arst_dout", 32'(dout[0]), 32'd0);
    chk("arst_valid", 32'(dv[0]), 32'd0);
    chk("arst_busy", 32'(bsy[0]), 32'd0);
    chk("arst_err_count", ec0, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 1'b1, 1'b1, 1'b0, 2'b10);
    idle(3);
    chk("post_rst_busy", 32'(bsy[0]), 32'd0);
    chk("post_rst_dout", 32'(dout[0]), 32'd0);

    // Instance 1: LSB first, 2-bit saturating error counter
    send_sym(1, 4'b0000, 2'b01, 2'b01, 0, 4'b0000, 1'b1, 8'd1);
    send_sym(1, 4'b0000, 2'b01, 2'b01, 0, 4'b0000, 1'b1, 8'd2);
    send_sym(1, 4'b0000, 2'b01, 2'b01, 0, 4'b0000, 1'b1, 8'd3);
    send_sym(1, 4'b0000, 2'b01, 2'b01, 0, 4'b0000, 1'b1, 8'd3);
    send_sym(1, 4'b0000, 2'b01, 2'b01, 0, 4'b0000, 1'b1, 8'd3);
    send_sym(1, 4'b1000, 2'b10, 2'b10, 0, 4'b0001, 1'b0, 8'd3);
    send_sym(1, 4'b1011, 2'b11, 2'b11, 0, 4'b0000, 1'b1, 8'd3);
    send_sym(1, 4'b1100, 2'b00, 2'b00, 1, 4'b0010, 1'b0, 8'd3);
    send_sym(1, 4'b0010, 2'b01, 2'b01, 0, 4'b0001, 1'b0, 8'd3);
    send_sym(1, 4'b1111, 2'b01, 2'b01, 0, 4'b0000, 1'b1, 8'd3);
    idle(3);

    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
